// File: rtl/stroke_pooler_pkg.sv
// stroke_pooler_pkg: shared geometry, state encoding and pixel indexing for the stroke pipeline
package stroke_pooler_pkg;
  localparam int SIZE = 52;
  localparam int POOL = 4;
  localparam int GRID = SIZE / POOL;
  localparam int NCELL = GRID * GRID;
  localparam int NPIX = SIZE * SIZE;
  localparam int PIW = $clog2(NPIX);
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  // Pixel (x,y) lives at bit y*SIZE+x, matching the drawing stage and the classifier.
  function automatic logic [PIW-1:0] pix_idx(input int x, input int y);
    return PIW'(y * SIZE + x);
  endfunction
endpackage

// File: rtl/stroke_pooler_if.sv
// stroke_pooler_if: bitmap capture from the drawing stage and feature handoff to the classifier
interface stroke_pooler_if;
  import stroke_pooler_pkg::*;
  logic track_valid;
  logic [6:0] track_pos;
  logic [NPIX-1:0] track;
  logic busy;
  logic feat_valid;
  logic feat_ready;
  logic [6:0] feat_pos;
  logic [NCELL-1:0] feat_map;
  logic [11:0] ink_count;
  logic [3:0] bbox_rmin;
  logic [3:0] bbox_rmax;
  logic [3:0] bbox_cmin;
  logic [3:0] bbox_cmax;
  logic empty;
  modport master (
    output track_valid, track_pos, track, feat_ready,
    input busy, feat_valid, feat_pos, feat_map, ink_count,
    input bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax, empty
  );
  modport slave (
    input track_valid, track_pos, track, feat_ready,
    output busy, feat_valid, feat_pos, feat_map, ink_count,
    output bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax, empty
  );
endinterface

// File: rtl/stroke_pooler_pool_cell_count.sv
// pool_cell_count: popcount of the POOLxPOOL pixel window of cell (r,c)
module pool_cell_count
  import stroke_pooler_pkg::*;
(
  input  logic [NPIX-1:0] bits,
  input  logic [3:0]      r,
  input  logic [3:0]      c,
  output logic [4:0]      cnt
);
  always_comb begin
    cnt = '0;
    for (int dy = 0; dy < POOL; dy++)
      for (int dx = 0; dx < POOL; dx++)
        cnt = cnt + 5'(bits[pix_idx(POOL * int'(c) + dx, POOL * int'(r) + dy)]);
  end
endmodule

// File: rtl/stroke_pooler.sv
// stroke_pooler: latches a stroke bitmap, pools it to a 13x13 occupancy map with ink count and bbox
module stroke_pooler
  import stroke_pooler_pkg::*;
#(
  parameter int THRESH = 2
) (
  input logic clk,
  input logic rst,
  stroke_pooler_if.slave bus
);
  localparam logic [3:0] LAST = 4'(GRID - 1);
  state_t state, nxt;
  logic [NPIX-1:0] bm;
  logic [6:0] pos;
  logic [3:0] r, c, rmin, rmax, cmin, cmax, rmin_n, rmax_n, cmin_n, cmax_n;
  logic [NCELL-1:0] map, map_n;
  logic [11:0] ink, ink_n;
  logic [4:0] cnt;
  logic hit, last, none;
  pool_cell_count u_cnt (.bits(bm), .r(r), .c(c), .cnt(cnt));
  assign bus.busy = state != IDLE;
  assign bus.feat_valid = state == DONE;
  always_comb begin
    hit = cnt >= 5'(THRESH);
    last = r == LAST && c == LAST;
    map_n = map | (NCELL'(hit) << (8'(r) * 8'(GRID) + 8'(c)));
    ink_n = ink + 12'(cnt);
    rmin_n = hit && r < rmin ? r : rmin;
    rmax_n = hit && r > rmax ? r : rmax;
    cmin_n = hit && c < cmin ? c : cmin;
    cmax_n = hit && c > cmax ? c : cmax;
    none = map_n == '0;
    nxt = state == IDLE && bus.track_valid ? SCAN :
          state == SCAN && last ? DONE :
          state == DONE && bus.feat_ready ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.feat_pos <= '0;
      bus.feat_map <= '0;
      bus.ink_count <= '0;
      bus.bbox_rmin <= '0;
      bus.bbox_rmax <= '0;
      bus.bbox_cmin <= '0;
      bus.bbox_cmax <= '0;
      bus.empty <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.track_valid) begin
        bm <= bus.track;
        pos <= bus.track_pos;
        map <= '0;
        ink <= '0;
        rmin <= 4'hf;
        cmin <= 4'hf;
        rmax <= '0;
        cmax <= '0;
        r <= '0;
        c <= '0;
      end
      if (state == SCAN) begin
        map <= map_n;
        ink <= ink_n;
        rmin <= rmin_n;
        rmax <= rmax_n;
        cmin <= cmin_n;
        cmax <= cmax_n;
        c <= c == LAST ? 4'd0 : c + 4'd1;
        r <= c == LAST ? r + 4'd1 : r;
      end
      // Results only move on entry to DONE so the previous answer stays visible during SCAN.
      if (state == SCAN && last) begin
        bus.feat_pos <= pos;
        bus.feat_map <= map_n;
        bus.ink_count <= ink_n;
        bus.bbox_rmin <= none ? 4'd0 : rmin_n;
        bus.bbox_rmax <= none ? 4'd0 : rmax_n;
        bus.bbox_cmin <= none ? 4'd0 : cmin_n;
        bus.bbox_cmax <= none ? 4'd0 : cmax_n;
        bus.empty <= none;
      end
    end
  end
endmodule

// File: tb/tb_stroke_pooler.sv
// tb_stroke_pooler: directed and random bitmaps checked against a pixel-level pooling model
module tb_stroke_pooler;
  import stroke_pooler_pkg::*;
  localparam int THRESH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int fails = 0;
  logic [NCELL-1:0] e_map;
  logic [11:0] e_ink;
  logic [3:0] e_rmin, e_rmax, e_cmin, e_cmax;
  logic e_empty;
  logic [6:0] e_pos;
  logic [NPIX-1:0] bm;
  logic [255:0] saved, saved_res;
  stroke_pooler_if bus ();
  stroke_pooler #(.THRESH(THRESH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] res();
    return 256'({bus.feat_pos, bus.feat_map, bus.ink_count, bus.bbox_rmin, bus.bbox_rmax,
                 bus.bbox_cmin, bus.bbox_cmax, bus.empty});
  endfunction

  function automatic logic [255:0] snap();
    return 256'({bus.feat_pos, bus.feat_map, bus.ink_count, bus.bbox_rmin, bus.bbox_rmax,
                 bus.bbox_cmin, bus.bbox_cmax, bus.empty, bus.feat_valid, bus.busy});
  endfunction

  // Reference: bin every set pixel into its cell, then threshold and take the extent.
  function automatic void model(input logic [NPIX-1:0] b);
    int cells[NCELL];
    int rlo = 99, rhi = -1, clo = 99, chi = -1, ink = 0;
    foreach (cells[k]) cells[k] = 0;
    for (int y = 0; y < SIZE; y++)
      for (int x = 0; x < SIZE; x++)
        if (b[y * SIZE + x]) begin
          cells[(y / POOL) * GRID + x / POOL]++;
          ink++;
        end
    e_map = '0;
    for (int k = 0; k < NCELL; k++)
      if (cells[k] >= THRESH) begin
        e_map[k] = 1'b1;
        if (k / GRID < rlo) rlo = k / GRID;
        if (k / GRID > rhi) rhi = k / GRID;
        if (k % GRID < clo) clo = k % GRID;
        if (k % GRID > chi) chi = k % GRID;
      end
    e_ink = 12'(ink);
    e_empty = rhi < 0;
    e_rmin = e_empty ? 4'd0 : 4'(rlo);
    e_rmax = e_empty ? 4'd0 : 4'(rhi);
    e_cmin = e_empty ? 4'd0 : 4'(clo);
    e_cmax = e_empty ? 4'd0 : 4'(chi);
  endfunction

  function automatic logic [NPIX-1:0] rand_bm(input int dens);
    logic [NPIX-1:0] b;
    for (int i = 0; i < NPIX; i++) b[i] = $urandom_range(0, 99) < dens;
    return b;
  endfunction

  task automatic start(input logic [NPIX-1:0] b, input logic [6:0] p);
    bus.track = b;
    bus.track_pos = p;
    bus.track_valid = 1'b1;
    @(negedge clk);
    bus.track_valid = 1'b0;
    model(b);
    e_pos = p;
    chk("busy_after_capture", 256'(bus.busy), 256'(1));
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!bus.feat_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 256'(n), 256'(169));
    chk({tag, "_map"}, 256'(bus.feat_map), 256'(e_map));
    chk({tag, "_ink"}, 256'(bus.ink_count), 256'(e_ink));
    chk({tag, "_bbox"}, 256'({bus.bbox_rmin, bus.bbox_rmax, bus.bbox_cmin, bus.bbox_cmax}),
        256'({e_rmin, e_rmax, e_cmin, e_cmax}));
    chk({tag, "_empty"}, 256'(bus.empty), 256'(e_empty));
    chk({tag, "_pos"}, 256'(bus.feat_pos), 256'(e_pos));
  endtask

  task automatic handshake(input string tag);
    saved_res = res();
    bus.feat_ready = 1'b1;
    @(negedge clk);
    bus.feat_ready = 1'b0;
    chk({tag, "_valid_drop"}, 256'({bus.feat_valid, bus.busy}), 256'(0));
    chk({tag, "_persist"}, res(), saved_res);
  endtask

  initial begin
    bus.track_valid = 1'b0;
    bus.track_pos = '0;
    bus.track = '0;
    bus.feat_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", snap(), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", snap(), '0);
    bm = '0;
    bm[5 * SIZE + 5] = 1'b1;
    start(bm, 7'd3);
    wait_result("single_pixel");
    handshake("single_pixel");
    bm = '0;
    for (int y = 4; y < 8; y++)
      for (int x = 8; x < 12; x++) bm[y * SIZE + x] = 1'b1;
    start(bm, 7'd40);
    chk("persist_during_scan", res(), saved_res);
    wait_result("block");
    chk("block_bit15", 256'(bus.feat_map), 256'(1) << 15);
    handshake("block");
    bm = '1;
    start(bm, 7'd80);
    wait_result("full");
    handshake("full");
    bm = '0;
    for (int x = 0; x < SIZE; x++) bm[x * SIZE + x] = 1'b1;
    start(bm, 7'd0);
    wait_result("diagonal");
    handshake("diagonal");
    start(rand_bm(10), 7'($urandom_range(0, 80)));
    wait_result("backpressure");
    saved = snap();
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        bus.track = rand_bm(50);
        bus.track_pos = 7'd77;
        bus.track_valid = 1'b1;
      end
      @(negedge clk);
      bus.track_valid = 1'b0;
      chk("hold", snap(), saved);
    end
    saved_res = res();
    bus.feat_ready = 1'b1;
    bus.track_valid = 1'b1;
    @(negedge clk);
    bus.feat_ready = 1'b0;
    bus.track_valid = 1'b0;
    chk("exit_edge_pulse_ignored", 256'({bus.feat_valid, bus.busy}), 256'(0));
    chk("exit_persist", res(), saved_res);
    start(rand_bm(30), 7'($urandom_range(0, 80)));
    repeat (80) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_scan_reset", snap(), '0);
    start(rand_bm(20), 7'($urandom_range(0, 80)));
    wait_result("after_reset");
    handshake("after_reset");
    bus.feat_ready = 1'b1;
    start(rand_bm(5), 7'($urandom_range(0, 80)));
    wait_result("ready_high");
    @(negedge clk);
    chk("ready_high_one_cycle_done", 256'({bus.feat_valid, bus.busy}), 256'(0));
    bus.feat_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      start(rand_bm(t == 0 ? 3 : t == 1 ? 8 : t == 2 ? 15 : 60), 7'($urandom_range(0, 80)));
      wait_result("random");
      handshake("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
